fft_out_reorder: RTL and testbench

//  Output stage of the 32-point pipelined FFT: accepts complex samples in bit-reversed frame order
//  and re-emits each frame in natural order (X[0]..X[31]). Ping-pong, two 32-entry banks: one bank

---
 rtl/fft_pkg.sv | 25 ++
 rtl/reorder_bank.sv | 32 +++
 rtl/fft_out_reorder.sv | 131 +++++++++++++
 tb/tb_fft_out_reorder.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared constants, bit-reverse helper and bank-state encoding for frame-buffered FFT stages.
package fft_pkg;

    localparam int DATA_W = 19;
    localparam int LOG2N  = 5;
    localparam int N      = 1 << LOG2N;

    localparam logic [LOG2N-1:0] CNT_LAST = LOG2N'(N - 1);

    typedef enum logic [1:0] {
        BANK_EMPTY    = 2'd0,
        BANK_FILLING  = 2'd1,
        BANK_FULL     = 2'd2,
        BANK_DRAINING = 2'd3
    } bank_state_t;

    function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] idx);
        logic [LOG2N-1:0] rev;
        for (int b = 0; b < LOG2N; b++) begin
            rev[b] = idx[LOG2N-1-b];
        end
        return rev;
    endfunction

endpackage

// File: rtl/reorder_bank.sv
// One frame of sample storage: N x {re,im} memory, one write port, one registered read port.
module reorder_bank
    import fft_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_en,
    input  logic [LOG2N-1:0]    wr_addr,
    input  logic [2*DATA_W-1:0] wr_data,
    input  logic                rd_en,
    input  logic [LOG2N-1:0]    rd_addr,
    output logic [2*DATA_W-1:0] rd_data
);

    logic [2*DATA_W-1:0] mem [N];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // The read register holds its value while rd_en is low, so it doubles as the output hold stage.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/fft_out_reorder.sv
// Ping-pong reorder buffer: bit-reversed frames in, natural-order frames out at 1 sample/clk.
// Optional out_last port enabled by defining FFT_REORDER_LAST_EN.
module fft_out_reorder
    import fft_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_r,
    input  logic [DATA_W-1:0] in_i,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_r,
    output logic [DATA_W-1:0] out_i
`ifdef FFT_REORDER_LAST_EN
    ,
    output logic              out_last
`endif
);

    logic [LOG2N-1:0]           wr_cnt_reg;
    logic [LOG2N-1:0]           rd_cnt_reg;
    logic                       wr_bank_reg;
    logic                       rd_bank_reg;
    logic                       out_sel_reg;
    logic                       out_valid_reg;
    bank_state_t                bank_state_reg [2];

    bank_state_t                wr_state;
    bank_state_t                rd_state;
    logic                       wr_fire;
    logic                       rd_avail;
    logic                       load;
    logic [LOG2N-1:0]           wr_addr;
    logic [2*DATA_W-1:0]        wr_data;
    logic [1:0]                 bank_wr_en;
    logic [1:0]                 bank_rd_en;
    logic [1:0][2*DATA_W-1:0]   bank_rd_data;

    // in_ready depends only on registered bank state, never on out_ready.
    assign wr_state = bank_state_reg[wr_bank_reg];
    assign rd_state = bank_state_reg[rd_bank_reg];
    assign in_ready = (wr_state == BANK_EMPTY) || (wr_state == BANK_FILLING);
    assign wr_fire  = in_valid && in_ready;
    assign rd_avail = (rd_state == BANK_FULL) || (rd_state == BANK_DRAINING);
    assign load     = (!out_valid_reg || out_ready) && rd_avail;
    assign wr_addr  = bitrev(wr_cnt_reg);
    assign wr_data  = {in_r, in_i};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_bank
            assign bank_wr_en[gi] = wr_fire && (wr_bank_reg == 1'(gi));
            assign bank_rd_en[gi] = load && (rd_bank_reg == 1'(gi));

            reorder_bank u_bank (
                .clk     (clk),
                .rst     (rst),
                .wr_en   (bank_wr_en[gi]),
                .wr_addr (wr_addr),
                .wr_data (wr_data),
                .rd_en   (bank_rd_en[gi]),
                .rd_addr (rd_cnt_reg),
                .rd_data (bank_rd_data[gi])
            );
        end
    endgenerate

    // A bank is never written and read on the same edge: writes need EMPTY/FILLING, reads FULL/DRAINING.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int b = 0; b < 2; b++) begin
                bank_state_reg[b] <= BANK_EMPTY;
            end
        end else begin
            for (int b = 0; b < 2; b++) begin
                if (bank_wr_en[b]) begin
                    bank_state_reg[b] <= (wr_cnt_reg == CNT_LAST) ? BANK_FULL : BANK_FILLING;
                end else if (bank_rd_en[b]) begin
                    bank_state_reg[b] <= (rd_cnt_reg == CNT_LAST) ? BANK_EMPTY : BANK_DRAINING;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_cnt_reg    <= '0;
            rd_cnt_reg    <= '0;
            wr_bank_reg   <= 1'b0;
            rd_bank_reg   <= 1'b0;
            out_sel_reg   <= 1'b0;
            out_valid_reg <= 1'b0;
        end else begin
            if (wr_fire) begin
                wr_cnt_reg <= wr_cnt_reg + 1'b1;
                if (wr_cnt_reg == CNT_LAST) begin
                    wr_bank_reg <= ~wr_bank_reg;
                end
            end
            if (load) begin
                rd_cnt_reg    <= rd_cnt_reg + 1'b1;
                out_sel_reg   <= rd_bank_reg;
                out_valid_reg <= 1'b1;
                if (rd_cnt_reg == CNT_LAST) begin
                    rd_bank_reg <= ~rd_bank_reg;
                end
            end else if (out_ready) begin
                out_valid_reg <= 1'b0;
            end
        end
    end

    // Output data comes straight from the bank read registers; out_sel_reg picks the last-loaded bank.
    assign out_valid = out_valid_reg;
    assign out_r     = bank_rd_data[out_sel_reg][2*DATA_W-1:DATA_W];
    assign out_i     = bank_rd_data[out_sel_reg][DATA_W-1:0];

`ifdef FFT_REORDER_LAST_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_last <= 1'b0;
        end else if (load) begin
            out_last <= (rd_cnt_reg == CNT_LAST);
        end else if (out_ready) begin
            out_last <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_fft_out_reorder.sv
// Directed and randomised checks of the bit-reversed to natural-order reorder buffer.
module tb_fft_out_reorder;
    import fft_pkg::*;

    localparam int DW = DATA_W;
    localparam int FN = N;

    logic          clk       = 1'b0;
    logic          rst       = 1'b0;
    logic          in_valid  = 1'b0;
    logic          out_ready = 1'b0;
    logic [DW-1:0] in_r      = '0;
    logic [DW-1:0] in_i      = '0;
    logic          in_ready;
    logic          out_valid;
    logic [DW-1:0] out_r;
    logic [DW-1:0] out_i;
`ifdef FFT_REORDER_LAST_EN
    logic          out_last;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    logic [2*DW-1:0] out_q [$];
    bit              last_q [$];

    always #5 clk = ~clk;

    fft_out_reorder dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_r      (in_r),
        .in_i      (in_i),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_r     (out_r),
        .out_i     (out_i)
`ifdef FFT_REORDER_LAST_EN
        ,
        .out_last  (out_last)
`endif
    );

    // Capture every accepted output sample mid-cycle, when inputs and outputs are stable.
    always @(negedge clk) begin
        if (out_valid && out_ready) begin
            out_q.push_back({out_r, out_i});
`ifdef FFT_REORDER_LAST_EN
            last_q.push_back(out_last);
`else
            last_q.push_back(1'b0);
`endif
        end
    end

    function automatic int rev_idx(input int k);
        int r = 0;
        for (int b = 0; b < LOG2N; b++) begin
            if ((k & (1 << b)) != 0) r = r | (1 << (LOG2N - 1 - b));
        end
        return r;
    endfunction

    // Drive one cycle of inputs at posedge+1; acc reports whether the coming edge takes the sample.
    task automatic step(input bit v, input logic [DW-1:0] r, input logic [DW-1:0] i,
                        input bit ordy, output bit acc);
        in_valid  = v;
        in_r      = r;
        in_i      = i;
        out_ready = ordy;
        acc       = v && in_ready;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        n_checks++;
        if (out_r !== '0 || out_i !== '0) begin n_fail++; $display("FAIL reset_out_data: got r=%0h i=%0h expected 0 0", out_r, out_i); end
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        rst = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || out_r !== '0 || out_i !== '0) begin
            n_fail++; $display("FAIL idle_after_reset: got v=%b r=%0h i=%0h expected 0 0 0", out_valid, out_r, out_i);
        end
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL idle_in_ready: got %b expected 1", in_ready); end
        $display("test_reset done");
    endtask

    task automatic test_single_frame();
        bit acc;
        int rejects = 0;
        logic [2*DW-1:0] got;
        logic [DW-1:0] exp_r, exp_i;
        out_q.delete();
        last_q.delete();
        for (int k = 0; k < FN; k++) begin
            step(1'b1, DW'(k), DW'(-k), 1'b1, acc);
            if (!acc) rejects++;
        end
        n_checks++;
        if (rejects != 0) begin n_fail++; $display("FAIL single_in_ready: got %0d rejected expected 0", rejects); end
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_latency_early: got out_valid=%b expected 0", out_valid); end
        step(1'b0, '0, '0, 1'b1, acc);
        n_checks++;
        if (out_valid !== 1'b1 || out_r !== '0 || out_i !== '0) begin
            n_fail++; $display("FAIL single_first_out: got v=%b r=%0h i=%0h expected 1 0 0", out_valid, out_r, out_i);
        end
        repeat (40) step(1'b0, '0, '0, 1'b1, acc);
        n_checks++;
        if (out_q.size() != FN) begin
            n_fail++; $display("FAIL single_count: got %0d samples expected %0d", out_q.size(), FN);
        end else begin
            for (int n = 0; n < FN; n++) begin
                got   = out_q[n];
                exp_r = DW'(rev_idx(n));
                exp_i = DW'(-rev_idx(n));
                n_checks++;
                if (got !== {exp_r, exp_i}) begin
                    n_fail++; $display("FAIL single_data[%0d]: got %0h/%0h expected %0h/%0h",
                                       n, got[2*DW-1:DW], got[DW-1:0], exp_r, exp_i);
                end
`ifdef FFT_REORDER_LAST_EN
                n_checks++;
                if (last_q[n] !== (n == FN - 1)) begin
                    n_fail++; $display("FAIL single_last[%0d]: got %b expected %b", n, last_q[n], (n == FN - 1));
                end
`endif
            end
        end
        $display("test_single_frame done, %0d samples out", out_q.size());
    endtask

    task automatic test_streaming();
        bit acc;
        int rejects = 0, vcount = 0, first = -1, lastc = -1, s;
        logic [2*DW-1:0] got;
        logic [DW-1:0] exp_r, exp_i;
        out_q.delete();
        for (int c = 0; c < 4 * FN + 40; c++) begin
            if (c < 4 * FN) begin
                step(1'b1, DW'(c), DW'(c * 3 + 1000), 1'b1, acc);
                if (!acc) rejects++;
            end else begin
                step(1'b0, '0, '0, 1'b1, acc);
            end
            if (out_valid) begin
                vcount++;
                if (first < 0) first = c;
                lastc = c;
            end
        end
        n_checks++;
        if (rejects != 0) begin n_fail++; $display("FAIL stream_in_ready: got %0d rejected expected 0", rejects); end
        n_checks++;
        if (vcount != 4 * FN || lastc - first + 1 != 4 * FN) begin
            n_fail++; $display("FAIL stream_continuous: got %0d valid over span %0d expected %0d", vcount, lastc - first + 1, 4 * FN);
        end
        n_checks++;
        if (out_q.size() != 4 * FN) begin
            n_fail++; $display("FAIL stream_count: got %0d expected %0d", out_q.size(), 4 * FN);
        end else begin
            for (int m = 0; m < 4 * FN; m++) begin
                s = (m / FN) * FN + rev_idx(m % FN);
                exp_r = DW'(s);
                exp_i = DW'(s * 3 + 1000);
                got = out_q[m];
                n_checks++;
                if (got !== {exp_r, exp_i}) begin
                    n_fail++; $display("FAIL stream_data[%0d]: got %0h/%0h expected %0h/%0h",
                                       m, got[2*DW-1:DW], got[DW-1:0], exp_r, exp_i);
                end
            end
        end
        $display("test_streaming done, %0d samples out", out_q.size());
    endtask

    task automatic test_backpressure();
        bit acc;
        int accepted = 0, s;
        logic [2*DW-1:0] got;
        logic [DW-1:0] exp_r, exp_i;
        out_q.delete();
        for (int c = 0; c < 150; c++) begin
            step(accepted < 3 * FN, DW'(500 + accepted), DW'(accepted * 7), 1'b0, acc);
            if (acc) accepted++;
        end
        n_checks++;
        if (accepted != 2 * FN) begin n_fail++; $display("FAIL bp_accepted: got %0d expected %0d", accepted, 2 * FN); end
        n_checks++;
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready: got %b expected 0", in_ready); end
        n_checks++;
        if (out_valid !== 1'b1 || out_r !== DW'(500) || out_i !== '0) begin
            n_fail++; $display("FAIL bp_hold: got v=%b r=%0h i=%0h expected 1 %0h 0", out_valid, out_r, out_i, DW'(500));
        end
        n_checks++;
        if (out_q.size() != 0) begin n_fail++; $display("FAIL bp_no_output: got %0d expected 0", out_q.size()); end
        for (int c = 0; c < 400 && (accepted < 3 * FN || out_q.size() < 3 * FN); c++) begin
            step(accepted < 3 * FN, DW'(500 + accepted), DW'(accepted * 7), 1'b1, acc);
            if (acc) accepted++;
        end
        n_checks++;
        if (accepted != 3 * FN || out_q.size() != 3 * FN) begin
            n_fail++; $display("FAIL bp_release_count: got in=%0d out=%0d expected %0d", accepted, out_q.size(), 3 * FN);
        end else begin
            for (int m = 0; m < 3 * FN; m++) begin
                s = (m / FN) * FN + rev_idx(m % FN);
                exp_r = DW'(500 + s);
                exp_i = DW'(s * 7);
                got = out_q[m];
                n_checks++;
                if (got !== {exp_r, exp_i}) begin
                    n_fail++; $display("FAIL bp_data[%0d]: got %0h/%0h expected %0h/%0h",
                                       m, got[2*DW-1:DW], got[DW-1:0], exp_r, exp_i);
                end
            end
        end
        $display("test_backpressure done, %0d samples out", out_q.size());
    endtask

    task automatic test_random();
        localparam int TOTAL = 20 * FN;
        bit acc, v, ordy;
        int accepted = 0, s;
        logic [2*DW-1:0] in_hist [TOTAL];
        logic [2*DW-1:0] got;
        logic [DW-1:0] cur_r, cur_i;
        out_q.delete();
        cur_r = DW'($urandom);
        cur_i = DW'($urandom);
        for (int c = 0; c < 20000 && out_q.size() < TOTAL; c++) begin
            v    = (accepted < TOTAL) && ($urandom_range(0, 9) < 7);
            ordy = (accepted >= TOTAL) || ($urandom_range(0, 9) < 6);
            step(v, cur_r, cur_i, ordy, acc);
            if (acc) begin
                in_hist[accepted] = {cur_r, cur_i};
                accepted++;
                cur_r = DW'($urandom);
                cur_i = DW'($urandom);
            end
        end
        n_checks++;
        if (accepted != TOTAL || out_q.size() != TOTAL) begin
            n_fail++; $display("FAIL rand_count: got in=%0d out=%0d expected %0d", accepted, out_q.size(), TOTAL);
        end else begin
            for (int m = 0; m < TOTAL; m++) begin
                s = (m / FN) * FN + rev_idx(m % FN);
                got = out_q[m];
                n_checks++;
                if (got !== in_hist[s]) begin
                    n_fail++; $display("FAIL rand_data[%0d]: got %0h expected %0h", m, got, in_hist[s]);
                end
            end
        end
        $display("test_random done, %0d samples out", out_q.size());
    endtask

    task automatic test_reset_mid_frame();
        bit acc;
        int accepted = 0;
        logic [2*DW-1:0] got;
        logic [DW-1:0] exp_r, exp_i;
        out_q.delete();
        for (int c = 0; c < 100 && accepted < 40; c++) begin
            step(1'b1, DW'(900 + accepted), DW'(accepted), 1'b0, acc);
            if (acc) accepted++;
        end
        for (int c = 0; c < 50 && out_q.size() < 5; c++) begin
            step(1'b0, '0, '0, 1'b1, acc);
        end
        n_checks++;
        if (accepted != 40 || out_q.size() != 5) begin
            n_fail++; $display("FAIL mid_setup: got in=%0d out=%0d expected 40 5", accepted, out_q.size());
        end
        out_ready = 1'b0;
        rst = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || out_r !== '0 || out_i !== '0) begin
            n_fail++; $display("FAIL mid_reset_out: got v=%b r=%0h i=%0h expected 0 0 0", out_valid, out_r, out_i);
        end
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL mid_reset_in_ready: got %b expected 1", in_ready); end
        @(posedge clk);
        #1;
        rst = 1'b1;
        step(1'b0, '0, '0, 1'b1, acc);
        out_q.delete();
        for (int k = 0; k < FN; k++) begin
            step(1'b1, DW'(2000 + k), DW'(k * 11), 1'b1, acc);
        end
        repeat (40) step(1'b0, '0, '0, 1'b1, acc);
        n_checks++;
        if (out_q.size() != FN) begin
            n_fail++; $display("FAIL mid_count: got %0d expected %0d", out_q.size(), FN);
        end else begin
            for (int n = 0; n < FN; n++) begin
                exp_r = DW'(2000 + rev_idx(n));
                exp_i = DW'(rev_idx(n) * 11);
                got = out_q[n];
                n_checks++;
                if (got !== {exp_r, exp_i}) begin
                    n_fail++; $display("FAIL mid_data[%0d]: got %0h/%0h expected %0h/%0h",
                                       n, got[2*DW-1:DW], got[DW-1:0], exp_r, exp_i);
                end
            end
        end
        $display("test_reset_mid_frame done, %0d samples out", out_q.size());
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_streaming();
        test_backpressure();
        test_random();
        test_reset_mid_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
